// File: rtl/timer_ctrl_pkg.sv
// Shared types and reset constants for the timer controller.
// The FSM state encoding and the latched configuration bundle live here.
package timer_ctrl_pkg;

  localparam int TIMER_WIDTH   = 16;
  localparam int TIMER_PRESC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } timer_state_t;

  typedef struct packed {
    logic [TIMER_WIDTH-1:0]   period;
    logic [TIMER_PRESC_W-1:0] prescale;
    logic                     oneshot;
  } timer_cfg_t;

  localparam timer_cfg_t CFG_RESET = '{
    period:   '1,
    prescale: '0,
    oneshot:  1'b0
  };

endpackage

// File: rtl/timer_ctrl_if.sv
// Configuration handshake bundle between a register master and the timer.
// The master offers a new config; the timer accepts it only while idle.
interface timer_ctrl_if #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_period;
  logic [PRESC_W-1:0] cfg_prescale;
  logic               cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_prescale,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_prescale,
    input  cfg_oneshot,
    output cfg_ready
  );

endinterface

// File: rtl/timer_ctrl_prescaler.sv
// Clock divider for the timer: emits a registered step every terminal+1
// enabled cycles; hold freezes both the divider and a pending step.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               hold,
  input  logic               en,
  input  logic [PRESC_W-1:0] terminal,
  output logic               step
);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (en && !hold) begin
      if (cnt == terminal) begin
        cnt  <= '0;
        step <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        step <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: FSM, config register and count/tick/done logic
// around a prescaler that paces the up-counter.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = TIMER_WIDTH,
  parameter int PRESC_W = TIMER_PRESC_W
) (
  input  logic             clk,
  input  logic             reset,
  timer_ctrl_if.slave      cfg,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count_val,
  output logic             tick,
  output logic             done
);

  timer_state_t     state_q, state_d;
  timer_cfg_t       cfg_q, cfg_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             step;

  // Divider is only live in RUN; a stop cycle freezes it in place.
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == ST_IDLE),
    .hold     (stop),
    .en       (state_q == ST_RUN),
    .terminal (cfg_q.prescale),
    .step     (step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= CFG_RESET;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          cfg_d.period   = cfg.cfg_period;
          cfg_d.prescale = cfg.cfg_prescale;
          cfg_d.oneshot  = cfg.cfg_oneshot;
        end
        if (start) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (step) begin
          if (count_q == cfg_q.period) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (cfg_q.oneshot) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign count_val     = count_q;
  assign tick          = tick_q;
  assign done          = done_q;

endmodule
